// File: rtl/aes_pkg.sv
// AES shared definitions: FIPS-197 S-box tables and a byte lookup helper.
// The inverse table and the inv argument exist only when INV_SBOX_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } sub_state_e;

  // Indexed by the full byte value: high nibble = row, low nibble = column.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef INV_SBOX_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction
`else
  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return SBOX[b];
  endfunction
`endif

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lookup lane. The inv select exists only when
// INV_SBOX_EN is defined.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
`ifdef INV_SBOX_EN
  input  logic       inv,
`endif
  output logic [7:0] out_byte
);

  always_comb begin
`ifdef INV_SBOX_EN
    out_byte = sbox_f(in_byte, inv);
`else
    out_byte = sbox_f(in_byte);
`endif
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes engine: LANES S-box lookups per clock over a WORD_BYTES word,
// valid/ready in and out. INV_SBOX_EN adds a per-word inverse-S-box select (inv port).
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int WORD_BYTES = 16,
  parameter int LANES      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*WORD_BYTES-1:0] in_data,
`ifdef INV_SBOX_EN
  input  logic                    inv,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data
);

  localparam int BEATS = WORD_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  if (WORD_BYTES < 1 || LANES < 1 || LANES > WORD_BYTES || (WORD_BYTES % LANES) != 0) begin : g_bad_cfg
    $error("sub_bytes_engine: LANES must be 1..WORD_BYTES and divide WORD_BYTES");
  end

  sub_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [8*WORD_BYTES-1:0] work_q, work_d;
`ifdef INV_SBOX_EN
  logic                    inv_q, inv_d;
`endif

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  // Lane l always looks at byte cnt*LANES + l, so beats walk up from byte 0.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[8*(int'(cnt_q)*LANES + l) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .in_byte (lane_in[l]),
`ifdef INV_SBOX_EN
      .inv     (inv_q),
`endif
      .out_byte(lane_out[l])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking on every flop so all of them sample pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: work is genuinely reset, not just qualified, so out_data reads 0 after reset.
      work_q  <= '0;
`ifdef INV_SBOX_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef INV_SBOX_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every target gets a hold default first so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef INV_SBOX_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SUB;
          cnt_d   = '0;
          work_d  = in_data;
`ifdef INV_SBOX_EN
          inv_d   = inv;
`endif
        end
      end
      SUB: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[8*(int'(cnt_q)*LANES + l) +: 8] = lane_out[l];
        end
        if (cnt_q == CNT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = SUB;
            cnt_d   = '0;
            work_d  = in_data;
`ifdef INV_SBOX_EN
            inv_d   = inv;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; in_ready looks through to out_ready so HOLD can hand over in one cycle.
  always_comb begin
    in_ready  = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    out_valid = !rst && (state_q == HOLD);
    out_data  = work_q;
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: the S-box reference is rebuilt from GF(2^8)
// inversion plus the affine map, expected words are queued at accept and popped by a monitor.
module tb_sub_bytes_engine;

  localparam int WB    = 16;
  localparam int LN    = 4;
  localparam int BEATS = WB / LN;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [8*WB-1:0] in_data, out_data;
`ifdef INV_SBOX_EN
  logic           inv_in, s_inv;
`endif

  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0]    s_in_data, s_out_data;

  always #5 clk = ~clk;

  sub_bytes_engine #(.WORD_BYTES(WB), .LANES(LN)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef INV_SBOX_EN
    .inv      (inv_in),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  sub_bytes_engine #(.WORD_BYTES(4), .LANES(4)) u_small (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_data  (s_in_data),
`ifdef INV_SBOX_EN
    .inv      (s_inv),
`endif
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_data (s_out_data)
  );

  typedef struct {
    logic [8*WB-1:0] data;
    int              acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         presenting = 0;
  bit         rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] y, s;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++)
        if (x != 0 && gf_mul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
      fwd_t[x] = s;
      inv_t[s] = 8'(x);
    end
  endtask

  function automatic logic [8*WB-1:0] model(input logic [8*WB-1:0] w, input bit iv, input int nb);
    logic [8*WB-1:0] r;
    r = '0;
    for (int j = 0; j < nb; j++)
      r[8*j +: 8] = iv ? inv_t[w[8*j +: 8]] : fwd_t[w[8*j +: 8]];
    return r;
  endfunction

  function automatic logic [8*WB-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at a negedge after the word is accepted.
  task automatic send(input logic [8*WB-1:0] w, input bit iv, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data  = w;
`ifdef INV_SBOX_EN
    inv_in   = iv;
`endif
    forever begin
      #2;
      if (in_ready) begin
        exp_q.push_back('{data: model(w, iv, WB), acc: cyc + 1});
        break;
      end
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand_word();
  endtask

  // Monitor: samples between the negedge drive and the next posedge.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      presenting = 0;
    end else if (out_valid) begin
      if (!presenting) begin
        presenting = 1;
        if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
        else check("latency", cyc - exp_q[0].acc, BEATS);
      end
      if (exp_q.size() != 0) check("out_data", out_data, exp_q[0].data);
      if (!out_ready) check("busy_in_ready", in_ready, 1'b0);
      else begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        presenting = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    int w;
    logic [8*WB-1:0] word, w2;
    logic [31:0] sa, sb;
    bit iv;

    build_tables();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
`ifdef INV_SBOX_EN
    inv_in = 1'b0; s_inv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_data", out_data, '0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    // All-zero word must become all 8'h63.
    send('0, 1'b0, w);
    repeat (6) @(negedge clk);
    check("zero_word_drained", exp_q.size(), 0);

    // Back-to-back random words, consumer always ready.
    for (int i = 0; i < 6; i++) send(rand_word(), 1'b0, w);

    // Backpressure: hold the result for 10 cycles with a second word waiting.
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    word = rand_word();
    w2   = rand_word();
    send(word, 1'b0, w);
    in_valid = 1'b1;
    in_data  = w2;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      #2;
      if (!out_valid) @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      #2;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_data", out_data, model(word, 1'b0, WB));
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(w2, 1'b0, w);
    check("bp_same_cycle_accept", w, 0);

`ifdef INV_SBOX_EN
    word = rand_word();
    word[15:0] = 16'hed63;
    send(word, 1'b1, w);
    word[7:0] = 8'h53;
    send(word, 1'b0, w);
`endif

    // Random consumer stalls and producer gaps.
    rand_ready = 1;
    fork
      while (rand_ready) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      iv = 1'b0;
`ifdef INV_SBOX_EN
      iv = $urandom_range(0, 1) == 1;
`endif
      send(rand_word(), iv, w);
    end
    rand_ready = 0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("random_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // Reset while the word sits at cnt=2: it must vanish.
    send(rand_word(), 1'b0, w);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_out_data", out_data, '0);
    send(rand_word(), 1'b0, w);
    check("post_rst_ready", w, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("post_rst_drained", exp_q.size(), 0);

    // 4-byte, 4-lane instance: one-cycle SUB, words accepted every 2 clk.
    sa = 32'h14DFF409;
    sb = $urandom;
    s_in_valid = 1'b1; s_in_data = sa;
    #2 check("small_accept_a", s_in_ready, 1'b1);
    @(negedge clk);
    s_in_data = sb;
    #2 check("small_sub_valid", s_out_valid, 1'b0);
    check("small_sub_ready", s_in_ready, 1'b0);
    @(negedge clk);
    #2 check("small_hold_valid", s_out_valid, 1'b1);
    check("small_known_vector", s_out_data, 32'hFA9EBF01);
    check("small_model_a", s_out_data, model({96'h0, sa}, 1'b0, 4));
    check("small_b2b_ready", s_in_ready, 1'b1);
    @(negedge clk);
    s_in_valid = 1'b0;
    #2 check("small_sub_b_valid", s_out_valid, 1'b0);
    @(negedge clk);
    #2 check("small_hold_b_valid", s_out_valid, 1'b1);
    check("small_model_b", s_out_data, model({96'h0, sb}, 1'b0, 4));
    @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
